// File: rtl/reg_window_ctrl_if.sv
// Bus bundle between reg_window_ctrl and its neighbours: the core command pulses,
// the register file's spill/fill port, and the memory stack port.
interface reg_window_ctrl_if #(
  parameter int unsigned WW = 2,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16
);
  logic          save;
  logic          restore;
  logic [WW-1:0] active_wnd;
  logic          busy;
  logic          wnd_err;
  logic [WW:0]   rf_idx;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output save, restore, rf_rdata, mem_rdata, mem_ack,
    input  active_wnd, busy, wnd_err, rf_idx, rf_we, rf_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  save, restore, rf_rdata, mem_rdata, mem_ack,
    output active_wnd, busy, wnd_err, rf_idx, rf_we, rf_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/reg_window_ctrl.sv
// Register-window controller: tracks the active window and spills/fills ring windows to a
// downward-growing memory stack. Define WND_STATS_EN to add spill_cnt/fill_cnt outputs.
module reg_window_ctrl #(
  parameter int unsigned NWND    = 4,
  parameter int unsigned WW      = 2,
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16,
  parameter logic [AW-1:0] SP_RST = 16'hFF00,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  reg_window_ctrl_if.slave  bus
`ifdef WND_STATS_EN
  ,
  output logic [15:0]       spill_cnt,
  output logic [15:0]       fill_cnt
`endif
);

  localparam logic [WW-1:0] RES_MAX = WW'(NWND - 1);
  localparam logic [WW-1:0] RES_MIN = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPILL_LO,
    S_SPILL_HI,
    S_SPILL_END,
    S_FILL_HI,
    S_FILL_LO,
    S_FILL_END
  } state_t;

  state_t               state_q, state_d;
  logic [WW-1:0]        active_q, active_d;
  logic [WW-1:0]        oldest_q, oldest_d;
  logic [WW-1:0]        resident_q, resident_d;
  logic [DEPTH_W-1:0]   spilled_q, spilled_d;
  logic [AW-1:0]        sp_q, sp_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
`ifdef WND_STATS_EN
  logic [15:0]          spill_cnt_q, spill_cnt_d;
  logic [15:0]          fill_cnt_q, fill_cnt_d;
`endif

  logic          save_cmd;
  logic          restore_cmd;
  logic          ring_full;
  logic          ring_last;
  logic          spill_sat;
  logic          can_fill;
  logic [WW-1:0] fill_tgt;
  logic          fill_word;

  // Simultaneous save and restore cancel each other and are dropped.
  always_comb begin
    save_cmd    = bus.save && !bus.restore;
    restore_cmd = bus.restore && !bus.save;
    ring_full   = (resident_q == RES_MAX);
    ring_last   = (resident_q == RES_MIN);
    spill_sat   = &spilled_q;
    can_fill    = (spilled_q != '0);
    fill_tgt    = active_q - 1'b1;
    fill_word   = (state_q == S_FILL_HI) || (state_q == S_FILL_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      active_q    <= '0;
      oldest_q    <= '0;
      resident_q  <= RES_MIN;
      spilled_q   <= '0;
      sp_q        <= SP_RST;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef WND_STATS_EN
      spill_cnt_q <= '0;
      fill_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      oldest_q    <= oldest_d;
      resident_q  <= resident_d;
      spilled_q   <= spilled_d;
      sp_q        <= sp_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef WND_STATS_EN
      spill_cnt_q <= spill_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (save_cmd && ring_full && !spill_sat) begin
          state_d = S_SPILL_LO;
        end else if (restore_cmd && ring_last && can_fill) begin
          state_d = S_FILL_HI;
        end
      end
      S_SPILL_LO:  if (bus.mem_ack) state_d = S_SPILL_HI;
      S_SPILL_HI:  if (bus.mem_ack) state_d = S_SPILL_END;
      S_SPILL_END: state_d = S_IDLE;
      S_FILL_HI:   if (bus.mem_ack) state_d = S_FILL_LO;
      S_FILL_LO:   if (bus.mem_ack) state_d = S_FILL_END;
      S_FILL_END:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Each word issues at the edge that accepts the previous one, so mem_req stays high across
  // both words; rf_rdata is captured into mem_wdata at that same edge.
  always_comb begin
    active_d    = active_q;
    oldest_d    = oldest_q;
    resident_d  = resident_q;
    spilled_d   = spilled_q;
    sp_d        = sp_q;
    busy_d      = busy_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef WND_STATS_EN
    spill_cnt_d = spill_cnt_q;
    fill_cnt_d  = fill_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (save_cmd) begin
          if (!ring_full) begin
            active_d   = active_q + 1'b1;
            resident_d = resident_q + 1'b1;
          end else if (spill_sat) begin
            err_d = 1'b1;
          end else begin
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            sp_d        = sp_q - 1'b1;
            mem_addr_d  = sp_q - 1'b1;
            mem_wdata_d = bus.rf_rdata;
          end
        end else if (restore_cmd) begin
          if (!ring_last) begin
            active_d   = active_q - 1'b1;
            resident_d = resident_q - 1'b1;
          end else if (!can_fill) begin
            err_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = sp_q;
          end
        end
      end
      S_SPILL_LO: begin
        if (bus.mem_ack) begin
          sp_d        = sp_q - 1'b1;
          mem_addr_d  = sp_q - 1'b1;
          mem_wdata_d = bus.rf_rdata;
        end
      end
      S_SPILL_HI: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      S_SPILL_END: begin
        busy_d    = 1'b0;
        active_d  = active_q + 1'b1;
        oldest_d  = oldest_q + 1'b1;
        spilled_d = spilled_q + 1'b1;
`ifdef WND_STATS_EN
        if (spill_cnt_q != '1) spill_cnt_d = spill_cnt_q + 1'b1;
`endif
      end
      S_FILL_HI: begin
        if (bus.mem_ack) begin
          sp_d       = sp_q + 1'b1;
          mem_addr_d = sp_q + 1'b1;
        end
      end
      S_FILL_LO: begin
        if (bus.mem_ack) begin
          sp_d      = sp_q + 1'b1;
          mem_req_d = 1'b0;
        end
      end
      S_FILL_END: begin
        busy_d    = 1'b0;
        active_d  = fill_tgt;
        oldest_d  = fill_tgt;
        spilled_d = spilled_q - 1'b1;
`ifdef WND_STATS_EN
        if (fill_cnt_q != '1) fill_cnt_d = fill_cnt_q + 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // rf_idx points one word ahead during a spill so rf_rdata is ready at the accepting edge.
  always_comb begin
    logic rf_we_c;
    rf_we_c        = fill_word && bus.mem_ack;
    bus.active_wnd = active_q;
    bus.busy       = busy_q;
    bus.wnd_err    = err_q;
    bus.mem_req    = mem_req_q;
    bus.mem_we     = mem_we_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
    bus.rf_we      = rf_we_c;
    bus.rf_wdata   = rf_we_c ? bus.mem_rdata : '0;
    unique case (state_q)
      S_SPILL_LO, S_SPILL_HI, S_SPILL_END: bus.rf_idx = {oldest_q, 1'b1};
      S_FILL_HI:                           bus.rf_idx = {fill_tgt, 1'b1};
      S_FILL_LO, S_FILL_END:               bus.rf_idx = {fill_tgt, 1'b0};
      default:                             bus.rf_idx = {oldest_q, 1'b0};
    endcase
  end

`ifdef WND_STATS_EN
  assign spill_cnt = spill_cnt_q;
  assign fill_cnt  = fill_cnt_q;
`endif

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Scoreboard bench for reg_window_ctrl: a memory responder and RF model drive the DUT,
// expected stack/RF transactions are queued by the stimulus and checked by a monitor.
module tb_reg_window_ctrl;
  localparam int unsigned WW = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_window_ctrl_if #(.WW(WW), .DW(DW), .AW(AW)) bus ();

`ifdef WND_STATS_EN
  logic [15:0] spill_cnt;
  logic [15:0] fill_cnt;
`endif

  reg_window_ctrl #(
    .NWND(4), .WW(WW), .DW(DW), .AW(AW), .SP_RST(16'hFF00), .DEPTH_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WND_STATS_EN
    ,
    .spill_cnt(spill_cnt),
    .fill_cnt(fill_cnt)
`endif
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } mem_txn_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } rf_txn_t;

  mem_txn_t    exp_mem[$];
  rf_txn_t     exp_rf[$];
  logic [15:0] rf_mem [8];
  logic [15:0] mem_model [logic [15:0]];
  logic        ack_en = 1'b1;
  int          resp_wait = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  assign bus.rf_rdata = rf_mem[bus.rf_idx];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ack arrives in the cycle after a request is seen.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.mem_ack = 1'b0;
        resp_wait   = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        resp_wait   = bus.mem_req ? 1 : 0;
      end else if (bus.mem_req && ack_en) begin
        if (resp_wait >= 1) begin
          bus.mem_ack = 1'b1;
          resp_wait   = 0;
          if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 16'h0BAD;
        end else begin
          resp_wait++;
        end
      end
    end
  end

  // Monitor: every completed stack access and RF fill write is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_ack) begin
        mem_txn_t a;
        a.we   = bus.mem_we;
        a.addr = bus.mem_addr;
        a.data = bus.mem_we ? bus.mem_wdata : bus.mem_rdata;
        if (exp_mem.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mem_unexpected: got %h, expected no access", a);
        end else begin
          check("mem_txn", 64'(a), 64'(exp_mem.pop_front()));
        end
      end
      if (bus.rf_we) begin
        rf_txn_t r;
        r.idx  = bus.rf_idx;
        r.data = bus.rf_wdata;
        if (exp_rf.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rf_unexpected: got %h, expected no write", r);
        end else begin
          check("rf_txn", 64'(r), 64'(exp_rf.pop_front()));
        end
        rf_mem[bus.rf_idx] = bus.rf_wdata;
      end
    end
  end

  task automatic cmd(input logic s, input logic r);
    @(negedge clk);
    bus.save    = s;
    bus.restore = r;
    @(negedge clk);
    bus.save    = 1'b0;
    bus.restore = 1'b0;
  endtask

  task automatic wait_idle(output int unsigned cycles);
    cycles = 0;
    while (bus.busy && cycles < 60) begin
      cycles++;
      @(negedge clk);
    end
    check("busy_timeout", 64'(bus.busy), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_spill(input int unsigned k);
    logic [15:0] base;
    logic [2:0]  o;
    base = 16'hFF00 - 16'(2 * k);
    o    = 3'(2 * (k % 4));
    exp_mem.push_back('{we: 1'b1, addr: base - 16'd1, data: 16'hA000 + 16'(o)});
    exp_mem.push_back('{we: 1'b1, addr: base - 16'd2, data: 16'hA001 + 16'(o)});
  endtask

  initial begin
    int unsigned cyc;
    bus.save    = 1'b0;
    bus.restore = 1'b0;
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'hA000 + 16'(i);

    repeat (3) @(negedge clk);
    check("rst_active", 64'(bus.active_wnd), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_err", 64'(bus.wnd_err), 64'(0));
    check("rst_req", 64'(bus.mem_req), 64'(0));
    check("rst_rf_we", 64'(bus.rf_we), 64'(0));
    check("rst_addr", 64'(bus.mem_addr), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Two saves fit in the ring.
    cmd(1'b1, 1'b0);
    check("s1_active1", 64'(bus.active_wnd), 64'(1));
    check("s1_busy1", 64'(bus.busy), 64'(0));
    check("s1_req1", 64'(bus.mem_req), 64'(0));
    cmd(1'b1, 1'b0);
    check("s1_active2", 64'(bus.active_wnd), 64'(2));
    check("s1_busy2", 64'(bus.busy), 64'(0));
    check("s1_req2", 64'(bus.mem_req), 64'(0));

    // Third save spills window 0.
    expect_spill(0);
    cmd(1'b1, 1'b0);
    check("s2_busy_on", 64'(bus.busy), 64'(1));
    wait_idle(cyc);
    check("s2_spill_cycles", 64'(cyc), 64'(5));
    check("s2_active", 64'(bus.active_wnd), 64'(3));
    check("s2_err", 64'(bus.wnd_err), 64'(0));

    // Restores back down; the third one fills window 0 from the stack.
    cmd(1'b0, 1'b1);
    check("s3_active2", 64'(bus.active_wnd), 64'(2));
    check("s3_busy2", 64'(bus.busy), 64'(0));
    cmd(1'b0, 1'b1);
    check("s3_active1", 64'(bus.active_wnd), 64'(1));
    check("s3_busy1", 64'(bus.busy), 64'(0));
    rf_mem[0] = 16'hDEAD;
    rf_mem[1] = 16'hBEEF;
    exp_mem.push_back('{we: 1'b0, addr: 16'hFEFE, data: 16'hA001});
    exp_mem.push_back('{we: 1'b0, addr: 16'hFEFF, data: 16'hA000});
    exp_rf.push_back('{idx: 3'd1, data: 16'hA001});
    exp_rf.push_back('{idx: 3'd0, data: 16'hA000});
    cmd(1'b0, 1'b1);
    check("s3_busy_on", 64'(bus.busy), 64'(1));
    wait_idle(cyc);
    check("s3_fill_cycles", 64'(cyc), 64'(5));
    check("s3_active0", 64'(bus.active_wnd), 64'(0));
    check("s3_rf0", 64'(rf_mem[0]), 64'(16'hA000));
    check("s3_rf1", 64'(rf_mem[1]), 64'(16'hA001));
`ifdef WND_STATS_EN
    check("s6_spill_cnt", 64'(spill_cnt), 64'(1));
    check("s6_fill_cnt", 64'(fill_cnt), 64'(1));
`endif

    // Stack pointer is back at FF00: the next spill reuses FEFF/FEFE.
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b0);
    expect_spill(0);
    cmd(1'b1, 1'b0);
    wait_idle(cyc);
    check("s3_respill_active", 64'(bus.active_wnd), 64'(3));

    // Underflow and cancelled commands.
    do_reset();
    cmd(1'b0, 1'b1);
    check("s4_err", 64'(bus.wnd_err), 64'(1));
    check("s4_active", 64'(bus.active_wnd), 64'(0));
    check("s4_busy", 64'(bus.busy), 64'(0));
    check("s4_req", 64'(bus.mem_req), 64'(0));
    cmd(1'b1, 1'b1);
    check("s4_both_active", 64'(bus.active_wnd), 64'(0));
    check("s4_err_sticky", 64'(bus.wnd_err), 64'(1));
    do_reset();
    check("s4_err_cleared", 64'(bus.wnd_err), 64'(0));
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b1);
    check("s4_both_active1", 64'(bus.active_wnd), 64'(1));
    check("s4_both_busy", 64'(bus.busy), 64'(0));

    // Reset during a stalled spill word.
    do_reset();
    ack_en = 1'b0;
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("s5_busy", 64'(bus.busy), 64'(1));
    check("s5_req", 64'(bus.mem_req), 64'(1));
    check("s5_addr", 64'(bus.mem_addr), 64'(16'hFEFF));
    check("s5_wdata", 64'(bus.mem_wdata), 64'(16'hA000));
    rst = 1'b1;
    #1;
    check("s5_rst_active", 64'(bus.active_wnd), 64'(0));
    check("s5_rst_busy", 64'(bus.busy), 64'(0));
    check("s5_rst_req", 64'(bus.mem_req), 64'(0));
    check("s5_rst_we", 64'(bus.mem_we), 64'(0));
    check("s5_rst_addr", 64'(bus.mem_addr), 64'(0));
    check("s5_rst_wdata", 64'(bus.mem_wdata), 64'(0));
    check("s5_rst_rf_idx", 64'(bus.rf_idx), 64'(0));
    check("s5_rst_err", 64'(bus.wnd_err), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    cmd(1'b1, 1'b0);
    check("s5_after_active", 64'(bus.active_wnd), 64'(1));
    check("s5_after_busy", 64'(bus.busy), 64'(0));

    // Spill counter saturation: 255 spills succeed, the 256th is refused.
    do_reset();
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b0);
    for (int unsigned k = 0; k < 255; k++) begin
      expect_spill(k);
      cmd(1'b1, 1'b0);
      wait_idle(cyc);
    end
    check("sat_active", 64'(bus.active_wnd), 64'(1));
    check("sat_err_before", 64'(bus.wnd_err), 64'(0));
`ifdef WND_STATS_EN
    check("sat_spill_cnt", 64'(spill_cnt), 64'(255));
`endif
    cmd(1'b1, 1'b0);
    check("sat_err", 64'(bus.wnd_err), 64'(1));
    check("sat_busy", 64'(bus.busy), 64'(0));
    check("sat_req", 64'(bus.mem_req), 64'(0));
    check("sat_active_kept", 64'(bus.active_wnd), 64'(1));

    repeat (4) @(negedge clk);
    check("mem_queue_drained", 64'(exp_mem.size()), 64'(0));
    check("rf_queue_drained", 64'(exp_rf.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
